// File: rtl/or1200_cust5_pkg.sv
// Shared constants for the l.cust5 lane buffer: op-code field values and FSM encoding.
package or1200_cust5_pkg;

    localparam int unsigned CUST5_OP_W  = 5;
    localparam int unsigned CUST5_IDX_W = 6;

    localparam logic [CUST5_OP_W-1:0] OPC_START  = 5'b00100;
    localparam logic [CUST5_OP_W-1:0] OPC_MIDDLE = 5'b00010;
    localparam logic [CUST5_OP_W-1:0] OPC_END    = 5'b00001;
    localparam logic [CUST5_OP_W-1:0] OPC_READ   = 5'b01000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_FEED = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } lanebuf_state_e;

endpackage

// File: rtl/or1200_cust5_wordram.sv
// Word storage with one write port and one registered read port.
// The read register holds when idle and can be zeroed, so it can drive a port directly.
module or1200_cust5_wordram #(
    parameter  int unsigned DW    = 32,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          rd_en_i,
    input  logic          rd_clr_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Storage array, no reset needed: unwritten entries are never returned.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register: clear has priority, otherwise load on enable, else hold.
    always_ff @(posedge clk) begin
        if (rst || rd_clr_i) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/or1200_cust5_lanebuf.sv
// l.cust5 lane buffer: collects operands from the pipeline, streams them to an
// engine, captures the engine's results and serves indexed reads back to the pipeline.
module or1200_cust5_lanebuf
    import or1200_cust5_pkg::*;
#(
    parameter int unsigned DW        = 32,
    parameter int unsigned IN_DEPTH  = 25,
    parameter int unsigned OUT_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_freeze,
    input  logic                   op_valid,
    input  logic [CUST5_OP_W-1:0]  op_code,
    input  logic [CUST5_IDX_W-1:0] op_index,
    input  logic [DW-1:0]          op_data,
    output logic                   op_stall,
    output logic [DW-1:0]          rd_data,
    output logic                   rd_valid,
    output logic                   err,
    output logic                   eng_in_valid,
    output logic [DW-1:0]          eng_in_data,
    output logic                   eng_in_last,
    input  logic                   eng_in_ready,
    input  logic                   eng_out_valid,
    input  logic [DW-1:0]          eng_out_data,
    input  logic                   eng_out_last
);

    localparam int unsigned ICW = $clog2(IN_DEPTH + 1);
    localparam int unsigned OCW = $clog2(OUT_DEPTH + 1);
    localparam int unsigned IAW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam int unsigned OAW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int unsigned RCW = CUST5_IDX_W + 1;

    lanebuf_state_e         state_q, state_d;
    logic [ICW-1:0]         in_cnt_q, in_cnt_d;
    logic [ICW-1:0]         ptr_q, ptr_d;
    logic [OCW-1:0]         out_cnt_q, out_cnt_d;
    logic                   err_q, err_d;
    logic                   pend_q, pend_d;
    logic [CUST5_IDX_W-1:0] pend_idx_q, pend_idx_d;
    logic                   rd_valid_q, rd_valid_d;
    logic                   in_valid_q, in_valid_d;
    logic                   in_last_q, in_last_d;

    logic                   op_acc;
    logic                   in_full;
    logic                   op_stall_c;
    logic                   rd_go;
    logic [CUST5_IDX_W-1:0] rd_idx;

    logic                   opr_we, opr_rd_en, opr_rd_clr;
    logic [IAW-1:0]         opr_waddr, opr_raddr;
    logic                   res_we, res_rd_en, res_rd_clr;
    logic [OAW-1:0]         res_waddr, res_raddr;

    assign op_acc  = op_valid && !ex_freeze;
    assign in_full = (in_cnt_q == ICW'(IN_DEPTH));

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            in_cnt_q   <= '0;
            ptr_q      <= '0;
            out_cnt_q  <= '0;
            err_q      <= 1'b0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
            rd_valid_q <= 1'b0;
            in_valid_q <= 1'b0;
            in_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_cnt_q   <= in_cnt_d;
            ptr_q      <= ptr_d;
            out_cnt_q  <= out_cnt_d;
            err_q      <= err_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
            rd_valid_q <= rd_valid_d;
            in_valid_q <= in_valid_d;
            in_last_q  <= in_last_d;
        end
    end

    // Next-state: operand feed, result capture, stalled read, then pipeline ops (start wins).
    always_comb begin
        state_d    = state_q;
        in_cnt_d   = in_cnt_q;
        ptr_d      = ptr_q;
        out_cnt_d  = out_cnt_q;
        err_d      = err_q;
        pend_d     = pend_q;
        pend_idx_d = pend_idx_q;
        rd_valid_d = 1'b0;
        in_valid_d = in_valid_q;
        in_last_d  = in_last_q;
        op_stall_c = 1'b0;
        rd_go      = 1'b0;
        rd_idx     = '0;
        opr_we     = 1'b0;
        opr_waddr  = '0;
        opr_rd_en  = 1'b0;
        opr_rd_clr = 1'b0;
        opr_raddr  = '0;
        res_we     = 1'b0;
        res_waddr  = '0;
        res_rd_en  = 1'b0;
        res_rd_clr = 1'b1;
        res_raddr  = '0;

        if (state_q == ST_FEED && in_valid_q && eng_in_ready) begin
            if (in_last_q) begin
                in_valid_d = 1'b0;
                in_last_d  = 1'b0;
                opr_rd_clr = 1'b1;
                state_d    = ST_WAIT;
            end else begin
                opr_rd_en = 1'b1;
                opr_raddr = IAW'(ptr_q);
                ptr_d     = ptr_q + ICW'(1);
                in_last_d = (ptr_q == in_cnt_q - ICW'(1));
            end
        end

        if (state_q == ST_FEED || state_q == ST_WAIT) begin
            if (eng_out_valid) begin
                if (out_cnt_q < OCW'(OUT_DEPTH)) begin
                    res_we    = 1'b1;
                    res_waddr = OAW'(out_cnt_q);
                    out_cnt_d = out_cnt_q + OCW'(1);
                end else begin
                    err_d = 1'b1;
                end
                if (eng_out_last) begin
                    state_d    = ST_DONE;
                    in_valid_d = 1'b0;
                    in_last_d  = 1'b0;
                    opr_rd_en  = 1'b0;
                    opr_rd_clr = 1'b1;
                end
            end
        end else if (eng_out_valid) begin
            err_d = 1'b1;
        end

        if (pend_q) begin
            if (state_q == ST_DONE) begin
                rd_go  = 1'b1;
                rd_idx = pend_idx_q;
                pend_d = 1'b0;
            end else begin
                op_stall_c = 1'b1;
            end
        end

        if (op_acc) begin
            case (op_code)
                OPC_START: begin
                    opr_we     = 1'b1;
                    opr_waddr  = '0;
                    in_cnt_d   = ICW'(1);
                    ptr_d      = '0;
                    out_cnt_d  = '0;
                    err_d      = 1'b0;
                    pend_d     = 1'b0;
                    op_stall_c = 1'b0;
                    rd_go      = 1'b0;
                    res_we     = 1'b0;
                    in_valid_d = 1'b0;
                    in_last_d  = 1'b0;
                    opr_rd_en  = 1'b0;
                    opr_rd_clr = 1'b1;
                    state_d    = ST_LOAD;
                end
                OPC_MIDDLE: begin
                    if (state_q == ST_LOAD && !in_full) begin
                        opr_we    = 1'b1;
                        opr_waddr = IAW'(in_cnt_q);
                        in_cnt_d  = in_cnt_q + ICW'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OPC_END: begin
                    if (state_q == ST_LOAD && !in_full) begin
                        opr_we     = 1'b1;
                        opr_waddr  = IAW'(in_cnt_q);
                        in_cnt_d   = in_cnt_q + ICW'(1);
                        opr_rd_en  = 1'b1;
                        opr_raddr  = '0;
                        ptr_d      = ICW'(1);
                        in_valid_d = 1'b1;
                        in_last_d  = (in_cnt_q == '0);
                        state_d    = ST_FEED;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OPC_READ: begin
                    if (state_q == ST_IDLE || state_q == ST_DONE) begin
                        rd_go  = 1'b1;
                        rd_idx = op_index;
                        pend_d = 1'b0;
                    end else begin
                        pend_d     = 1'b1;
                        pend_idx_d = op_index;
                        op_stall_c = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (rd_go) begin
            rd_valid_d = 1'b1;
            res_raddr  = OAW'(rd_idx);
            if (RCW'(rd_idx) < RCW'(out_cnt_q)) begin
                res_rd_en  = 1'b1;
                res_rd_clr = 1'b0;
            end
        end
    end

    or1200_cust5_wordram #(
        .DW    (DW),
        .DEPTH (IN_DEPTH)
    ) u_opr_ram (
        .clk      (clk),
        .rst      (rst),
        .we_i     (opr_we),
        .waddr_i  (opr_waddr),
        .wdata_i  (op_data),
        .rd_en_i  (opr_rd_en),
        .rd_clr_i (opr_rd_clr),
        .raddr_i  (opr_raddr),
        .rdata_o  (eng_in_data)
    );

    or1200_cust5_wordram #(
        .DW    (DW),
        .DEPTH (OUT_DEPTH)
    ) u_res_ram (
        .clk      (clk),
        .rst      (rst),
        .we_i     (res_we),
        .waddr_i  (res_waddr),
        .wdata_i  (eng_out_data),
        .rd_en_i  (res_rd_en),
        .rd_clr_i (res_rd_clr),
        .raddr_i  (res_raddr),
        .rdata_o  (rd_data)
    );

    assign op_stall     = op_stall_c;
    assign rd_valid     = rd_valid_q;
    assign err          = err_q;
    assign eng_in_valid = in_valid_q;
    assign eng_in_last  = in_last_q;

endmodule

// File: tb/tb_or1200_cust5_lanebuf.sv
// Bench for the cust5 lane buffer: two configurations share one stimulus stream
// (DW=32/IN 25/OUT 16 and DW=64/IN 8/OUT 25); results are predicted from the operand list.
module tb_or1200_cust5_lanebuf;
    import or1200_cust5_pkg::*;

    logic        clk = 1'b0;
    logic        rst, ex_freeze, op_valid;
    logic [4:0]  op_code;
    logic [5:0]  op_index;
    logic [63:0] op_data;
    logic        eng_in_ready, eng_out_valid, eng_out_last;
    logic [63:0] eng_out_data;

    logic        a_op_stall, a_rd_valid, a_err, a_in_valid, a_in_last;
    logic [31:0] a_rd_data, a_in_data;
    logic        b_op_stall, b_rd_valid, b_err, b_in_valid, b_in_last;
    logic [63:0] b_rd_data, b_in_data;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] ops [32];

    always #5 clk = ~clk;

    or1200_cust5_lanebuf #(.DW(32), .IN_DEPTH(25), .OUT_DEPTH(16)) dut_a (
        .clk(clk), .rst(rst), .ex_freeze(ex_freeze), .op_valid(op_valid),
        .op_code(op_code), .op_index(op_index), .op_data(op_data[31:0]),
        .op_stall(a_op_stall), .rd_data(a_rd_data), .rd_valid(a_rd_valid), .err(a_err),
        .eng_in_valid(a_in_valid), .eng_in_data(a_in_data), .eng_in_last(a_in_last),
        .eng_in_ready(eng_in_ready), .eng_out_valid(eng_out_valid),
        .eng_out_data(eng_out_data[31:0]), .eng_out_last(eng_out_last)
    );

    or1200_cust5_lanebuf #(.DW(64), .IN_DEPTH(8), .OUT_DEPTH(25)) dut_b (
        .clk(clk), .rst(rst), .ex_freeze(ex_freeze), .op_valid(op_valid),
        .op_code(op_code), .op_index(op_index), .op_data(op_data),
        .op_stall(b_op_stall), .rd_data(b_rd_data), .rd_valid(b_rd_valid), .err(b_err),
        .eng_in_valid(b_in_valid), .eng_in_data(b_in_data), .eng_in_last(b_in_last),
        .eng_in_ready(eng_in_ready), .eng_out_valid(eng_out_valid),
        .eng_out_data(eng_out_data), .eng_out_last(eng_out_last)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [4:0] code, input logic [5:0] idx, input logic [63:0] d);
        op_valid = 1'b1;
        op_code  = code;
        op_index = idx;
        op_data  = d;
        tick();
        op_valid = 1'b0;
    endtask

    task automatic load_job(input int n);
        op(OPC_START, 6'd0, ops[0]);
        for (int i = 1; i < n - 1; i++) op(OPC_MIDDLE, 6'd0, ops[i]);
        op(OPC_END, 6'd0, ops[n-1]);
    endtask

    // Acts as the engine's input side; mode 0 always ready, 1 toggling, 2 random.
    task automatic feed(input int n, input int mode, input bit with_b);
        int          k;
        int          cyc;
        bit          hold_v;
        logic [63:0] hold_d;
        k = 0; cyc = 0; hold_v = 1'b0; hold_d = '0;
        chk("feed_first_valid", 64'(a_in_valid), 64'd1);
        while (k < n && cyc < 400) begin
            case (mode)
                0:       eng_in_ready = 1'b1;
                1:       eng_in_ready = ((cyc % 2) == 1);
                default: eng_in_ready = 1'($urandom_range(0, 1));
            endcase
            if (hold_v) begin
                chk("hold_valid", 64'(a_in_valid), 64'd1);
                chk("hold_data", 64'(a_in_data), hold_d);
            end
            hold_v = a_in_valid && !eng_in_ready;
            hold_d = 64'(a_in_data);
            if (a_in_valid && eng_in_ready) begin
                chk("feed_data_a", 64'(a_in_data), {32'd0, ops[k][31:0]});
                chk("feed_last_a", 64'(a_in_last), 64'(k == n - 1));
                if (with_b) chk("feed_data_b", b_in_data, ops[k]);
                k++;
            end
            tick();
            cyc++;
        end
        eng_in_ready = 1'b0;
        chk("feed_count", 64'(k), 64'(n));
        chk("wait_valid_a", 64'(a_in_valid), 64'd0);
    endtask

    // Engine returns each operand plus 0x10, last on the n-th word.
    task automatic respond(input int n);
        for (int i = 0; i < n; i++) begin
            eng_out_valid = 1'b1;
            eng_out_data  = ops[i] + 64'h10;
            eng_out_last  = (i == n - 1);
            tick();
        end
        eng_out_valid = 1'b0;
        eng_out_last  = 1'b0;
    endtask

    task automatic read_chk(input int idx, input int n, input bit with_b);
        int          na;
        int          nb;
        logic [63:0] ea;
        logic [63:0] eb;
        na = (n < 16) ? n : 16;
        nb = (n < 25) ? n : 25;
        ea = '0;
        eb = '0;
        if (idx < na) ea = {32'd0, 32'(ops[idx] + 64'h10)};
        if (idx < nb) eb = ops[idx] + 64'h10;
        op(OPC_READ, 6'(idx), 64'd0);
        chk("rd_valid_a", 64'(a_rd_valid), 64'd1);
        chk("rd_data_a", 64'(a_rd_data), ea);
        if (with_b) begin
            chk("rd_valid_b", 64'(b_rd_valid), 64'd1);
            chk("rd_data_b", b_rd_data, eb);
        end
    endtask

    task automatic run_job(input int n, input int mode, input bit with_b);
        load_job(n);
        chk("err_after_load_a", 64'(a_err), 64'd0);
        feed(n, mode, with_b);
        respond(n);
        chk("err_a", 64'(a_err), 64'(n > 16));
        if (with_b) chk("err_b", 64'(b_err), 64'(n > 25));
        for (int i = 0; i < n; i++) read_chk(i, n, with_b);
        read_chk(15, n, with_b);
        tick();
        chk("rd_idle_valid", 64'(a_rd_valid), 64'd0);
        chk("rd_idle_data", 64'(a_rd_data), 64'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; ex_freeze = 1'b0; op_valid = 1'b0; op_code = '0; op_index = '0;
        op_data = '0; eng_in_ready = 1'b0; eng_out_valid = 1'b0; eng_out_last = 1'b0;
        eng_out_data = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_err", 64'(a_err), 64'd0);
        chk("rst_in_valid", 64'(a_in_valid), 64'd0);
        chk("rst_rd_valid", 64'(a_rd_valid), 64'd0);
        chk("rst_stall", 64'(a_op_stall), 64'd0);
        chk("rst_in_valid_b", 64'(b_in_valid), 64'd0);
        read_chk(3, 0, 1'b1);

        // Directed load and read back: 1..7
        for (int i = 0; i < 7; i++) ops[i] = 64'(i + 1);
        run_job(7, 0, 1'b1);

        // Backpressure with toggling ready, random 64-bit operands
        for (int i = 0; i < 6; i++) ops[i] = {$urandom, $urandom};
        run_job(6, 1, 1'b1);

        // Early read during WAIT, then frozen read not accepted
        n = 4;
        for (int i = 0; i < n; i++) ops[i] = {$urandom, $urandom};
        load_job(n);
        feed(n, 2, 1'b1);
        op_valid = 1'b1; op_code = OPC_READ; op_index = 6'd0;
        #1;
        chk("stall_comb", 64'(a_op_stall), 64'd1);
        tick();
        ex_freeze = 1'b1;
        #1;
        chk("stall_held", 64'(a_op_stall), 64'd1);
        for (int i = 0; i < n; i++) begin
            eng_out_valid = 1'b1;
            eng_out_data  = ops[i] + 64'h10;
            eng_out_last  = (i == n - 1);
            #1;
            chk("stall_wait", 64'(a_op_stall), 64'd1);
            chk("stall_no_rd", 64'(a_rd_valid), 64'd0);
            tick();
        end
        eng_out_valid = 1'b0; eng_out_last = 1'b0;
        #1;
        chk("stall_done_a", 64'(a_op_stall), 64'd0);
        chk("stall_done_b", 64'(b_op_stall), 64'd0);
        chk("stall_done_rd", 64'(a_rd_valid), 64'd0);
        op_valid = 1'b0; ex_freeze = 1'b0;
        tick();
        chk("early_rd_valid", 64'(a_rd_valid), 64'd1);
        chk("early_rd_data_a", 64'(a_rd_data), {32'd0, 32'(ops[0] + 64'h10)});
        chk("early_rd_data_b", b_rd_data, ops[0] + 64'h10);
        tick();
        chk("early_rd_after", 64'(a_rd_valid), 64'd0);
        chk("early_rd_after_data", 64'(a_rd_data), 64'd0);
        op_valid = 1'b1; op_code = OPC_READ; op_index = 6'd1; ex_freeze = 1'b1;
        tick();
        op_valid = 1'b0; ex_freeze = 1'b0;
        chk("frozen_rd", 64'(a_rd_valid), 64'd0);
        read_chk(1, n, 1'b1);

        // Protocol errors and operand depth limit (config A holds 25)
        rst = 1'b1; tick(); rst = 1'b0;
        op(OPC_MIDDLE, 6'd0, 64'd9);
        chk("err_mid_idle_a", 64'(a_err), 64'd1);
        chk("err_mid_idle_b", 64'(b_err), 64'd1);
        op(OPC_START, 6'd0, 64'd1);
        chk("err_clr_start", 64'(a_err), 64'd0);
        for (int i = 0; i < 24; i++) op(OPC_MIDDLE, 6'd0, 64'(i + 2));
        chk("err_at_depth", 64'(a_err), 64'd0);
        op(OPC_MIDDLE, 6'd0, 64'd99);
        chk("err_overflow", 64'(a_err), 64'd1);
        op(OPC_END, 6'd0, 64'd100);
        chk("overflow_no_feed", 64'(a_in_valid), 64'd0);
        chk("overflow_err_sticky", 64'(a_err), 64'd1);
        for (int i = 0; i < 25; i++) ops[i] = {$urandom, $urandom};
        run_job(25, 2, 1'b0);

        // Reset mid-FEED then a fresh job
        for (int i = 0; i < 5; i++) ops[i] = {$urandom, $urandom};
        load_job(5);
        tick(); tick();
        chk("pre_rst_feed", 64'(a_in_valid), 64'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_rst_in_valid", 64'(a_in_valid), 64'd0);
        chk("mid_rst_in_last", 64'(a_in_last), 64'd0);
        chk("mid_rst_in_data", 64'(a_in_data), 64'd0);
        chk("mid_rst_rd_valid", 64'(a_rd_valid), 64'd0);
        chk("mid_rst_rd_data", 64'(a_rd_data), 64'd0);
        chk("mid_rst_err", 64'(a_err), 64'd0);
        chk("mid_rst_stall", 64'(a_op_stall), 64'd0);
        chk("mid_rst_in_data_b", b_in_data, 64'd0);
        eng_in_ready = 1'b1;
        tick();
        eng_in_ready = 1'b0;
        chk("idle_no_feed", 64'(a_in_valid), 64'd0);
        read_chk(0, 0, 1'b1);
        n = int'($urandom_range(2, 7));
        for (int i = 0; i < n; i++) ops[i] = {$urandom, $urandom};
        run_job(n, 2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
